layer1_feature_deserializer: RTL and testbench
==============================================

// Module: layer1_feature_deserializer
// PURPOSE
//   Upstream feeder for the first LUT layer. Gathers a narrow stream of quantised input features into the
//   128-bit feature vector that the layer-1 LUT neurons use as their address bus.
//   Uses valid/ready on both sides, checks frame length against s_last, and double-buffers:
//   the next frame is collected while the current vector is held for the consumer.
// PARAMETERS
//   FEAT_W      4    bits per quantised feature
//   N_FEAT      32   features per vector; VEC_W = N_FEAT*FEAT_W = 128
//   BEAT_FEAT   4    features per input beat; BEAT_W = 16, N_BEATS = N_FEAT/BEAT_FEAT = 8
//   ERR_CNT_W   8    width of the saturating frame-error counter
// PORTS
//   clk        in   1       single clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   s_valid    in   1       input beat valid
//   s_ready    out  1       input beat accepted when s_valid && s_ready
//   s_data     in   BEAT_W  features 4k..4k+3 of beat k; feature j of beat at s_data[4j+3:4j]
//   s_last     in   1       marks final beat of a frame
//   m_valid    out  1       m_vec holds a complete vector
//   m_ready    in   1       consumer (layer-1 LUT stage register) takes vector
//   m_vec      out  VEC_W   feature f at m_vec[4f+3:4f]; wired straight to layer-1 address
//   frame_err  out  1       1-cycle pulse on short or long frame
//   err_cnt    out  ERR_CNT_W  saturating count of frame_err pulses
// BEHAVIOUR
//   Reset (rst_n low, async): state=COLLECT, beat=0, asm=0, m_valid=0, m_vec=0, frame_err=0, err_cnt=0.
//   s_ready is a decode of state: 1 in COLLECT and DROP, 0 in HOLD. During reset s_ready=1.
//   State COLLECT, on an accepted beat:
//     - asm[beat*BEAT_W +: BEAT_W] <= s_data.
//     - beat<7, !s_last: beat++.
//     - beat<7, s_last (short frame): frame_err pulse next cycle; beat<=0; partial frame discarded.
//     - beat==7, s_last (complete): beat<=0. If output slot free (!m_valid || m_ready), then
//       m_vec <= {s_data, asm[111:0]} and m_valid<=1 next cycle. Otherwise latch into asm and go to HOLD.
//     - beat==7, !s_last (long frame): frame_err pulse; beat<=0; go to DROP.
//   State HOLD: s_ready=0. When !m_valid || m_ready, then m_vec<=asm, m_valid<=1, go to COLLECT.
//   State DROP: accept and discard beats. Accepted beat with s_last: go to COLLECT. No output, no further error.
//   Output: m_valid and m_vec stay stable while m_valid && !m_ready.
//     m_valid clears after the handshake unless a new vector loads in the same cycle.
//     A handshake and a load in the same cycle give back-to-back vectors with no bubble.
//   Latency: last beat accepted in cycle N, so m_valid=1 in cycle N+1.
//   Throughput: 1 beat/cycle sustained while m_ready=1, i.e. one vector per 8 cycles.
//   err_cnt increments on each frame_err and saturates at 2^ERR_CNT_W-1 with no wrap.
//   Reset mid-frame or mid-HOLD loses all partial and held data with no error pulse.
//   Invalid beats (s_valid=0) change nothing. s_data is ignored when not accepted.
// STRUCTURE
//   Shared package lut_nn_pkg holds:
//     - FEAT_W, N_FEAT, VEC_W, BEAT_W, N_BEATS constants.
//     - deser_state_t enum {COLLECT, HOLD, DROP}.
//     These are reused by layer1..layerN wrappers.
//   One sub-module: feature_vec_slice, a VEC_W-wide valid/ready holding register that produces m_valid/m_vec.
//   The FSM, beat counter and assembly register stay in the top.
// TESTING
//   1. 8 beats s_data=16'h3210,16'h7654,..., s_last on beat 8, m_ready=1
//      -> m_valid one cycle after beat 8; m_vec[3:0]=0, m_vec[127:124]=F-pattern; frame_err=0.
//   2. Two frames back-to-back with m_ready=0 until cycle 20
//      -> frame 1 held stable; frame 2 goes to HOLD with s_ready=0.
//      m_ready=1 gives frame 1 then frame 2 on consecutive cycles.
//   3. s_last on beat 3 -> frame_err pulse, err_cnt=1, no m_valid.
//      Next 8-beat frame is delivered correctly.
//   4. 10-beat frame, s_last on beat 10 -> frame_err once after beat 8; beats 9-10 dropped.
//      Next frame is correct; err_cnt=1.
//   5. rst_n low for 1 cycle after beat 5 -> all outputs 0.
//      Fresh 8-beat frame then yields the correct vector with no stale bits.
//   6. Force 300 short frames -> err_cnt saturates at 255.

Source files
------------

// File: rtl/lut_nn_pkg.sv
`default_nettype none
// ============================================================================
// Module : lut_nn_pkg
// Brief  : Shared sizing constants and deserializer state type for LUT-NN layers.
// Rev    : 1.0
// ============================================================================
package lut_nn_pkg;

    localparam int FEAT_W     = 4;
    localparam int N_FEAT     = 32;
    localparam int VEC_W      = N_FEAT * FEAT_W;
    localparam int BEAT_FEAT  = 4;
    localparam int BEAT_W     = BEAT_FEAT * FEAT_W;
    localparam int N_BEATS    = N_FEAT / BEAT_FEAT;
    localparam int BEAT_IDX_W = $clog2(N_BEATS);
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DROP    = 2'd2
    } deser_state_t;

endpackage
`default_nettype wire

// File: rtl/layer1_feature_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module : layer1_feature_deserializer_if
// Brief  : Beat-in / vector-out valid-ready bundle of the layer-1 deserializer.
// Rev    : 1.0
// ============================================================================
interface layer1_feature_deserializer_if
    import lut_nn_pkg::*;
();
    logic              s_valid;
    logic              s_ready;
    logic [BEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [VEC_W-1:0]  m_vec;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_vec
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_vec
    );

endinterface
`default_nettype wire

// File: rtl/layer1_feature_deserializer_vec_slice.sv
`default_nettype none
// ============================================================================
// Module : feature_vec_slice
// Brief  : Single-entry valid/ready holding register for a full feature vector.
// Rev    : 1.0
// ============================================================================
module feature_vec_slice
    import lut_nn_pkg::*;
#(
    parameter int W = VEC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_vec,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_vec
);

    logic         r_valid;
    logic [W-1:0] r_vec;

    // Caller only asserts i_load when the slot is free or being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_vec   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_vec   <= i_vec;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_vec   = r_vec;

endmodule
`default_nettype wire

// File: rtl/layer1_feature_deserializer.sv
`default_nettype none
// ============================================================================
// Module : layer1_feature_deserializer
// Brief  : Packs 16-bit feature beats into the 128-bit layer-1 address vector,
//          checking frame length and double-buffering against the consumer.
// Rev    : 1.0
// ============================================================================
module layer1_feature_deserializer
    import lut_nn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    layer1_feature_deserializer_if.slave bus,
    output logic                  frame_err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam logic [1:0] S_COLLECT = COLLECT;
    localparam logic [1:0] S_HOLD    = HOLD;
    localparam logic [1:0] S_DROP    = DROP;
    localparam logic [BEAT_IDX_W-1:0] C_LAST_BEAT = BEAT_IDX_W'(N_BEATS - 1);

    logic [1:0]            r_state;
    logic [BEAT_IDX_W-1:0] r_beat;
    logic [VEC_W-1:0]      r_asm;
    logic                  r_frame_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic                  w_s_ready;
    logic                  w_acc;
    logic                  w_collect_acc;
    logic                  w_last_beat;
    logic                  w_done;
    logic                  w_err;
    logic                  w_m_valid;
    logic                  w_slot_free;
    logic                  w_load;
    logic [VEC_W-1:0]      w_load_vec;

    assign w_s_ready     = (r_state != S_HOLD);
    assign w_acc         = bus.s_valid && w_s_ready;
    assign w_collect_acc = w_acc && (r_state == S_COLLECT);
    assign w_last_beat   = (r_beat == C_LAST_BEAT);
    assign w_done        = w_collect_acc && w_last_beat && bus.s_last;
    assign w_err         = w_collect_acc && (w_last_beat != bus.s_last);
    assign w_slot_free   = !w_m_valid || bus.m_ready;
    assign w_load        = w_slot_free && (w_done || (r_state == S_HOLD));
    // Direct path bypasses the assembly register for the final beat to save a cycle.
    assign w_load_vec    = (r_state == S_HOLD) ? r_asm
                                               : {bus.s_data, r_asm[VEC_W-BEAT_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
            r_beat  <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_collect_acc) begin
                        if (w_last_beat || bus.s_last) begin
                            r_beat <= '0;
                        end else begin
                            r_beat <= r_beat + BEAT_IDX_W'(1);
                        end
                        if (w_last_beat && !bus.s_last) begin
                            r_state <= S_DROP;
                        end else if (w_done && !w_slot_free) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_slot_free) begin
                        r_state <= S_COLLECT;
                    end
                end
                S_DROP: begin
                    if (w_acc && bus.s_last) begin
                        r_state <= S_COLLECT;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < N_BEATS; k++) begin : g_asm
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_asm[k*BEAT_W +: BEAT_W] <= '0;
                end else if (w_collect_acc && (r_beat == BEAT_IDX_W'(k))) begin
                    r_asm[k*BEAT_W +: BEAT_W] <= bus.s_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_frame_err <= w_err;
            if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    feature_vec_slice #(
        .W (VEC_W)
    ) u_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_vec   (w_load_vec),
        .i_ready (bus.m_ready),
        .o_valid (w_m_valid),
        .o_vec   (bus.m_vec)
    );

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign frame_err   = r_frame_err;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_layer1_feature_deserializer.sv
`default_nettype none
// ============================================================================
// Module : tb_layer1_feature_deserializer
// Brief  : Self-checking bench with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_layer1_feature_deserializer;
    import lut_nn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    layer1_feature_deserializer_if u_if ();

    layer1_feature_deserializer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (u_if.slave),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: beats of the open frame, drop flag, expected vectors, error total.
    logic [BEAT_W-1:0] cur_q[$];
    logic [VEC_W-1:0]  exp_q[$];
    bit                dropping = 1'b0;
    int                m_errs   = 0;
    int                n_pulses = 0;

    function automatic logic [VEC_W-1:0] pack_beats();
        logic [VEC_W-1:0] v = '0;
        for (int k = 0; k < N_BEATS; k++) v[k*BEAT_W +: BEAT_W] = cur_q[k];
        return v;
    endfunction

    task automatic model_beat(input logic [BEAT_W-1:0] d, input logic l);
        if (dropping) begin
            if (l) dropping = 1'b0;
        end else begin
            cur_q.push_back(d);
            if (cur_q.size() == N_BEATS) begin
                if (l) exp_q.push_back(pack_beats());
                else begin
                    m_errs++;
                    dropping = 1'b1;
                end
                cur_q.delete();
            end else if (l) begin
                m_errs++;
                cur_q.delete();
            end
        end
    endtask

    function automatic int sat_errs();
        return (m_errs > 255) ? 255 : m_errs;
    endfunction

    bit               prev_stall = 1'b0;
    logic [VEC_W-1:0] prev_vec;

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_q.delete();
            exp_q.delete();
            dropping   = 1'b0;
            m_errs     = 0;
            n_pulses   = 0;
            prev_stall = 1'b0;
        end else begin
            if (u_if.s_valid && u_if.s_ready) model_beat(u_if.s_data, u_if.s_last);
            if (frame_err) n_pulses++;
            if (prev_stall) begin
                chk("stall_valid", 128'(u_if.m_valid), 128'(1));
                chk("stall_vec", u_if.m_vec, prev_vec);
            end
            if (u_if.m_valid && u_if.m_ready) begin
                if (exp_q.size() == 0) chk("m_valid_unexpected", 128'(u_if.m_valid), 128'(0));
                else chk("vec", u_if.m_vec, exp_q.pop_front());
            end
            prev_stall = u_if.m_valid && !u_if.m_ready;
            prev_vec   = u_if.m_vec;
        end
    end

    bit ready_cmd  = 1'b1;
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        u_if.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    logic [BEAT_W-1:0] beat_data[16];

    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
        bit acc;
        int guard = 0;
        u_if.s_valid = 1'b1;
        u_if.s_data  = d;
        u_if.s_last  = l;
        do begin
            @(negedge clk);
            acc = u_if.s_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("beat_timeout", 128'(acc), 128'(1));
        u_if.s_valid = 1'b0;
        u_if.s_data  = 16'(32'($urandom));
        u_if.s_last  = 1'($urandom);
    endtask

    task automatic send_frame(input int nb, input bit gaps);
        for (int k = 0; k < nb; k++) begin
            send_beat(beat_data[k], k == nb - 1);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) beat_data[k] = 16'(32'($urandom));
    endtask

    function automatic logic [VEC_W-1:0] data_vec();
        logic [VEC_W-1:0] v = '0;
        for (int k = 0; k < N_BEATS; k++) v[k*BEAT_W +: BEAT_W] = beat_data[k];
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, 128'(u_if.m_valid), 128'(0));
        chk({tag, "_m_vec"}, u_if.m_vec, 128'(0));
        chk({tag, "_s_ready"}, 128'(u_if.s_ready), 128'(1));
        chk({tag, "_frame_err"}, 128'(frame_err), 128'(0));
        chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2 check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic settle(input string tag);
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(sat_errs()));
        chk({tag, "_err_pulses"}, 128'(n_pulses), 128'(m_errs));
        chk({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    logic [VEC_W-1:0] v1, v2, vp;

    initial begin
        u_if.s_valid = 1'b0;
        u_if.s_data  = '0;
        u_if.s_last  = 1'b0;
        #2 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: nibble-ramp frame, latency and content
        for (int k = 0; k < N_BEATS; k++)
            beat_data[k] = (k % 2 == 0) ? 16'h3210 + 16'h8888 * 16'(k % 4 / 2) : 16'h7654 + 16'h8888 * 16'(k % 4 / 2);
        vp = '0;
        for (int f = 0; f < N_FEAT; f++) vp[f*FEAT_W +: FEAT_W] = 4'(f % 16);
        send_frame(8, 1'b0);
        @(negedge clk);
        #2;
        chk("t1_latency_valid", 128'(u_if.m_valid), 128'(1));
        chk("t1_vec", u_if.m_vec, vp);
        chk("t1_feat0", 128'(u_if.m_vec[3:0]), 128'(0));
        chk("t1_feat31", 128'(u_if.m_vec[127:124]), 128'(4'hF));
        chk("t1_frame_err", 128'(frame_err), 128'(0));
        settle("t1");

        // 2: back-pressure, second frame parks in HOLD
        do_reset();
        ready_cmd = 1'b0;
        fill_random(); v1 = data_vec(); send_frame(8, 1'b0);
        fill_random(); v2 = data_vec(); send_frame(8, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        chk("t2_hold_s_ready", 128'(u_if.s_ready), 128'(0));
        chk("t2_hold_valid", 128'(u_if.m_valid), 128'(1));
        chk("t2_hold_vec1", u_if.m_vec, v1);
        ready_cmd = 1'b1;
        @(negedge clk);
        #2 chk("t2_first_vec", u_if.m_vec, v1);
        @(negedge clk);
        #2;
        chk("t2_second_valid", 128'(u_if.m_valid), 128'(1));
        chk("t2_second_vec", u_if.m_vec, v2);
        settle("t2");

        // 3: short frame then a good one
        do_reset();
        fill_random(); send_frame(3, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk("t3_err_cnt", 128'(err_cnt), 128'(1));
        chk("t3_no_valid", 128'(u_if.m_valid), 128'(0));
        fill_random(); send_frame(8, 1'b0);
        settle("t3");

        // 4: 10-beat frame, drop tail, then a good one
        do_reset();
        fill_random(); send_frame(10, 1'b0);
        fill_random(); send_frame(8, 1'b0);
        settle("t4");
        chk("t4_err_cnt_one", 128'(err_cnt), 128'(1));

        // 5: reset mid-frame, then a fresh frame
        fill_random(); send_frame(5, 1'b0);
        do_reset();
        fill_random(); v1 = data_vec(); send_frame(8, 1'b0);
        @(negedge clk);
        #2 chk("t5_fresh_vec", u_if.m_vec, v1);
        settle("t5");

        // 6: saturation of the error counter
        do_reset();
        for (int i = 0; i < 300; i++) send_beat(16'(32'($urandom)), 1'b1);
        settle("t6");
        chk("t6_saturated", 128'(err_cnt), 128'(255));

        // Random frames, gaps and consumer stalls
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            int nb;
            r  = $urandom_range(0, 9);
            nb = (r == 6) ? $urandom_range(1, 7) : (r == 7) ? $urandom_range(9, 11) : 8;
            fill_random();
            send_frame(nb, 1'b1);
        end
        settle("rand");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
